// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath, with a bounded memory ready handshake.
// The optional ori support is compiled in only when MCCTRL_ORI_EN is defined.
module mc_main_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_JUMP   = 4'd11,
`ifdef MCCTRL_ORI_EN
    S_ORIEX  = 4'd12,
`endif
    S_ERR    = 4'd13
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MCCTRL_ORI_EN
  localparam logic [5:0] OP_ORI  = 6'b001101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       in_wait;
  logic       timeout;

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    logic [2:0] r;
    case (f)
      6'b100000: r = ALU_ADD;
      6'b100010: r = ALU_SUB;
      6'b100100: r = ALU_AND;
      6'b100101: r = ALU_OR;
      6'b101010: r = ALU_SLT;
      default:   r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Timeout fires at the end of the last tolerated not-ready cycle; ready in that cycle wins.
  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = in_wait && !mem_ready && (wait_q == WAIT_LAST);
  assign state   = state_q;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and wait-counter update.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE; else if (timeout) state_d = S_ERR; else state_d = S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MCCTRL_ORI_EN
          OP_ORI:       state_d = S_ORIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: if (Op == OP_SW) state_d = S_MEMWR; else state_d = S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB; else if (timeout) state_d = S_ERR; else state_d = S_MEMRD;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH; else if (timeout) state_d = S_ERR; else state_d = S_MEMWR;
      S_EXEC, S_ADDIEX: state_d = S_ALUWB;
`ifdef MCCTRL_ORI_EN
      S_ORIEX:  state_d = S_ALUWB;
`endif
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase

    if ((state_d != state_q) || mem_ready) begin
      wait_d = 8'd0;
    end else if (in_wait) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Output decode from the current state plus Zero, mem_ready and Op.
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    PCEn       = 1'b0;
    IorD       = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 3'b000;
    PCSrc      = 2'b00;
    ALUControl = ALU_ADD;
    mem_err    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 3'b001;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
      end
      S_DECODE: ALUSrcB = 3'b011;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 3'b010;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu(Funct);
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 3'b010;
      end
`ifdef MCCTRL_ORI_EN
      S_ORIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 3'b100;
        ALUControl = ALU_OR;
      end
`endif
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = (Op == OP_R);
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        PCEn       = Zero;
      end
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      S_ERR:   mem_err = 1'b1;
      default: mem_err = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed scoreboard bench for mc_main_ctrl: expected state/outputs queued per cycle, compared at negedge.
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       Zero, mem_ready;
  logic       MemRead, MemWrite, IRWrite, RegWrite, PCEn, IorD, MemtoReg, RegDst, ALUSrcA;
  logic [2:0] ALUSrcB, ALUControl;
  logic [1:0] PCSrc;
  logic       mem_err;
  logic [3:0] state;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
                         MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
                         ADDIEX = 4'd10, JUMP = 4'd11, ORIEX = 4'd12, ERR = 4'd13;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [17:0] outs;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  mc_main_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .Zero(Zero), .mem_ready(mem_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .PCEn(PCEn),
    .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  // Reference output table, packed as {MemRead,MemWrite,IRWrite,RegWrite,PCEn,IorD,MemtoReg,RegDst,ALUSrcA,ALUSrcB,PCSrc,ALUControl,mem_err}.
  function automatic logic [17:0] model(input logic [3:0] st, input logic [5:0] o, input logic [5:0] fn,
                                        input logic z, input logic r);
    logic mr, mw, irw, rw, pce, iord, m2r, rd, asa, me;
    logic [2:0] asb, alu;
    logic [1:0] pcs;
    {mr, mw, irw, rw, pce, iord, m2r, rd, asa, me} = 10'd0;
    asb = 3'd0; pcs = 2'd0; alu = 3'b010;
    case (st)
      FETCH:  begin mr = 1'b1; asb = 3'b001; irw = r; pce = r; end
      DECODE: asb = 3'b011;
      MEMADR: begin asa = 1'b1; asb = 3'b010; end
      MEMRD:  begin iord = 1'b1; mr = 1'b1; end
      MEMWB:  begin m2r = 1'b1; rw = 1'b1; end
      MEMWR:  begin iord = 1'b1; mw = 1'b1; end
      EXEC: begin
        asa = 1'b1;
        if (fn == 6'b100010) alu = 3'b110;
        else if (fn == 6'b100100) alu = 3'b000;
        else if (fn == 6'b100101) alu = 3'b001;
        else if (fn == 6'b101010) alu = 3'b111;
        else alu = 3'b010;
      end
      ALUWB:  begin rw = 1'b1; rd = (o == 6'b000000); end
      BRANCH: begin asa = 1'b1; alu = 3'b110; pcs = 2'b01; pce = z; end
      ADDIEX: begin asa = 1'b1; asb = 3'b010; end
      JUMP:   begin pcs = 2'b10; pce = 1'b1; end
      ORIEX:  begin asa = 1'b1; asb = 3'b100; alu = 3'b001; end
      ERR:    me = 1'b1;
      default: me = 1'b0;
    endcase
    return {mr, mw, irw, rw, pce, iord, m2r, rd, asa, asb, pcs, alu, me};
  endfunction

  task automatic check_front();
    exp_t e;
    logic [17:0] obs;
    e = sb.pop_front();
    obs = {MemRead, MemWrite, IRWrite, RegWrite, PCEn, IorD, MemtoReg, RegDst, ALUSrcA,
           ALUSrcB, PCSrc, ALUControl, mem_err};
    compared++;
    assert (state === e.st) else begin
      mismatched++;
      $error("FAIL %s state: observed %0d expected %0d", e.tag, state, e.st);
    end
    compared++;
    assert (obs === e.outs) else begin
      mismatched++;
      $error("FAIL %s outputs: observed %b expected %b", e.tag, obs, e.outs);
    end
  endtask

  // One clock cycle: drive ready/Zero, queue the expectation, compare at negedge, move past posedge.
  task automatic cyc(input string tag, input logic r, input logic z, input logic [3:0] est);
    exp_t e;
    mem_ready = r;
    Zero      = z;
    e.tag  = tag;
    e.st   = est;
    e.outs = model(est, op, funct, z, r);
    sb.push_back(e);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = 6'd0; funct = 6'd0; Zero = 1'b0; mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cyc("reset", i[0], 1'b1, IDLE);
    rst_n = 1'b1;
    cyc("idle", 1'b0, 1'b0, IDLE);

    // lw with two FETCH waits and one MEMRD wait
    op = 6'b100011;
    cyc("lw_f0", 1'b0, 1'b0, FETCH);
    cyc("lw_f1", 1'b0, 1'b0, FETCH);
    cyc("lw_f2", 1'b1, 1'b0, FETCH);
    cyc("lw_dec", 1'b0, 1'b0, DECODE);
    cyc("lw_adr", 1'b0, 1'b0, MEMADR);
    cyc("lw_rd0", 1'b0, 1'b0, MEMRD);
    cyc("lw_rd1", 1'b1, 1'b0, MEMRD);
    cyc("lw_wb", 1'b0, 1'b0, MEMWB);

    op = 6'b000000; funct = 6'b100010;
    cyc("r_f", 1'b1, 1'b0, FETCH);
    cyc("r_dec", 1'b0, 1'b0, DECODE);
    cyc("r_exec", 1'b0, 1'b0, EXEC);
    cyc("r_wb", 1'b0, 1'b0, ALUWB);

    op = 6'b000100;
    cyc("beq1_f", 1'b1, 1'b1, FETCH);
    cyc("beq1_dec", 1'b0, 1'b1, DECODE);
    cyc("beq1_br", 1'b0, 1'b1, BRANCH);
    cyc("beq0_f", 1'b1, 1'b0, FETCH);
    cyc("beq0_dec", 1'b0, 1'b0, DECODE);
    cyc("beq0_br", 1'b1, 1'b0, BRANCH);

    op = 6'b000010;
    cyc("j_f", 1'b1, 1'b0, FETCH);
    cyc("j_dec", 1'b0, 1'b0, DECODE);
    cyc("j_jmp", 1'b0, 1'b0, JUMP);

    op = 6'b001000;
    cyc("addi_f", 1'b1, 1'b0, FETCH);
    cyc("addi_dec", 1'b0, 1'b0, DECODE);
    cyc("addi_ex", 1'b0, 1'b0, ADDIEX);
    cyc("addi_wb", 1'b0, 1'b0, ALUWB);

    op = 6'b001101;
    cyc("ori_f", 1'b1, 1'b0, FETCH);
    cyc("ori_dec", 1'b0, 1'b0, DECODE);
`ifdef MCCTRL_ORI_EN
    cyc("ori_ex", 1'b0, 1'b0, ORIEX);
    cyc("ori_wb", 1'b0, 1'b0, ALUWB);
`endif

    op = 6'b111111;
    cyc("nop_f", 1'b1, 1'b0, FETCH);
    cyc("nop_dec", 1'b0, 1'b0, DECODE);

    // sw ready on the 15th wait cycle: no error
    op = 6'b101011;
    cyc("sw_f", 1'b1, 1'b0, FETCH);
    cyc("sw_dec", 1'b0, 1'b0, DECODE);
    cyc("sw_adr", 1'b0, 1'b0, MEMADR);
    for (int i = 0; i < 14; i++) cyc("sw_wait", 1'b0, 1'b0, MEMWR);
    cyc("sw_last_rdy", 1'b1, 1'b0, MEMWR);

    // sw never ready: ERR after exactly 15 wait cycles
    cyc("swto_f", 1'b1, 1'b0, FETCH);
    cyc("swto_dec", 1'b0, 1'b0, DECODE);
    cyc("swto_adr", 1'b0, 1'b0, MEMADR);
    for (int i = 0; i < 15; i++) cyc("swto_wait", 1'b0, 1'b0, MEMWR);
    for (int i = 0; i < 3; i++) cyc("err_hold", i[0], 1'b1, ERR);

    rst_n = 1'b0;
    cyc("err_reset", 1'b1, 1'b0, IDLE);
    rst_n = 1'b1;
    cyc("idle2", 1'b0, 1'b0, IDLE);

    // reset asserted while RegWrite is high in MEMWB
    op = 6'b100011;
    cyc("lw2_f", 1'b1, 1'b0, FETCH);
    cyc("lw2_dec", 1'b0, 1'b0, DECODE);
    cyc("lw2_adr", 1'b0, 1'b0, MEMADR);
    cyc("lw2_rd", 1'b1, 1'b0, MEMRD);
    rst_n = 1'b0;
    cyc("abort", 1'b1, 1'b1, IDLE);
    rst_n = 1'b1;
    cyc("idle3", 1'b0, 1'b0, IDLE);
    cyc("fetch3", 1'b0, 1'b0, FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Main control FSM of the multi-cycle MIPS datapath. It sits directly upstream of the datapath selector muxes (2- to 5-input) and the register/memory enables. Each cycle it decodes the current state, the instruction opcode and funct, and the ALU Zero flag into mux selects, write enables and ALU control. It also runs a bounded ready-handshake with instruction/data memory.

## Interface
- MEM_WAIT_MAX, 15: maximum consecutive not-ready cycles tolerated in a memory wait state (1..255).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Op  in  6  opcode from IR (stable from DECODE until next FETCH)
- Funct  in  6  funct field from IR
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- MemRead, MemWrite  out  1  memory request strobes
- IRWrite, RegWrite  out  1  IR / register-file write enables
- PCEn  out  1  PC load enable (PCWrite | Branch&Zero)
- IorD, MemtoReg, RegDst, ALUSrcA  out  1  MUX2 selects
- ALUSrcB  out  3  MUX5 select: 000 reg B, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext imm
- PCSrc  out  2  MUX3 select: 00 ALU result, 01 ALUOut, 10 jump target
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- mem_err  out  1  sticky memory-timeout flag
- state  out  4  current state (debug)

## Operation
- States and codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, ADDIEX 10, JUMP 11, ORIEX 12, ERR 13.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, ori 001101.
- Transitions:
  - IDLE→FETCH.
  - FETCH→DECODE on mem_ready, else stay.
  - DECODE→MEMADR (lw/sw), EXEC (R), BRANCH, ADDIEX, JUMP, ORIEX (ori). Any other opcode→FETCH, treated as a nop.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB on mem_ready. MEMWB→FETCH.
  - MEMWR→FETCH on mem_ready.
  - EXEC, ADDIEX and ORIEX→ALUWB. ALUWB→FETCH.
  - BRANCH and JUMP→FETCH.
  - ERR is absorbing.
- Outputs per state. Any signal not listed is 0; ALUControl defaults to 010.
  - FETCH: MemRead=1, ALUSrcB=001. IRWrite=PCEn=mem_ready.
  - DECODE: ALUSrcB=011.
  - MEMADR: ALUSrcA=1, ALUSrcB=010.
  - MEMRD: IorD=1, MemRead=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXEC: ALUSrcA=1, ALUSrcB=000. ALUControl from Funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, others→010.
  - ADDIEX: ALUSrcA=1, ALUSrcB=010.
  - ORIEX: ALUSrcA=1, ALUSrcB=100, ALUControl=001.
  - ALUWB: RegWrite=1, RegDst=(Op==000000).
  - BRANCH: ALUSrcA=1, ALUSrcB=000, ALUControl=110, PCSrc=01, PCEn=Zero.
  - JUMP: PCSrc=10, PCEn=1.
  - ERR: all enables 0, mem_err=1.
- Wait counter:
  - Cleared on every state change and in any cycle with mem_ready=1.
  - Increments each wait-state cycle (FETCH, MEMRD, MEMWR) that has mem_ready=0.
  - When the MEM_WAIT_MAX-th consecutive not-ready cycle ends, the next state is ERR.
  - mem_ready=1 in the limit cycle wins over the timeout.

## Timing
- Moore outputs are decoded from the state register. PCEn, IRWrite and ALUWB RegDst also depend combinationally on Zero, mem_ready and Op.
- While rst_n=0: state=IDLE, wait counter=0, mem_err=0, every enable 0, all selects 0, ALUControl=010. Reset asserted mid-instruction aborts it immediately, with no write enables high.
- Latency with zero wait states, counted FETCH through the last state:
  - beq and j: 3 cycles.
  - R-type, addi, ori and sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle adds one cycle.
- MemRead/MemWrite stay high continuously until the cycle in which mem_ready=1. The memory must complete in that same cycle.

## Configuration
- MCCTRL_ORI_EN defined: ori decodes to ORIEX, which drives ALUSrcB=100 and ALUControl=001.
- MCCTRL_ORI_EN undefined: ori is an unknown opcode (DECODE→FETCH), ORIEX is absent from the RTL, and ALUSrcB never equals 100.

## Test plan
- Reset: rst_n=0 for 3 cycles, then release → state 0 then 1. While reset is low, all enables are 0 and ALUControl=010.
- lw, mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD → sequence 1,1,1,2,3,4,4,5,1. RegWrite=1 and MemtoReg=1 only in state 5.
- R-type, Funct=100010, no waits → EXEC shows ALUControl=110. ALUWB shows RegDst=1, RegWrite=1.
- beq with Zero=1, then beq with Zero=0 → PCEn=1 with PCSrc=01 in the first BRANCH; PCEn=0 in the second.
- MEM_WAIT_MAX=15, mem_ready held 0 in MEMWR → ERR after exactly 15 wait cycles, mem_err=1 held until reset. Repeat with ready on the 15th cycle → FETCH, no error.
- ori (001101): with the macro → ALUSrcB=100 and ALUWB has RegDst=0. Without the macro → DECODE→FETCH and RegWrite stays 0.
